// File: rtl/inst_fetch_buf_if.sv
// rtl/inst_fetch_buf_if.sv - PC-stage, instruction-memory and decode signals of the fetch buffer
//
// Optional feature macro: INST_FETCH_ALIGN_CHK_EN (adds id_exc_o).
// Modports:
//   master - the fetch buffer: drives pc_take_o, mem_req_o/mem_addr_o and id_* outputs
//   slave  - the surroundings: PC stage, instruction memory and decode
// Signals:
//   pc_i/ce_i/pc_take_o              fetch address hand-off from the PC stage
//   mem_req_o/mem_addr_o             word read request, held until mem_ack_i
//   mem_ack_i/mem_rdata_i            read completion and data
//   id_valid_o/id_ready_i            FIFO head presented to decode
//   id_pc_o/id_inst_o[/id_exc_o]     contents of the FIFO head
//   flush_i                          redirect: discard everything fetched or pending

interface inst_fetch_buf_if;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        pc_take_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        flush_i;
`ifdef INST_FETCH_ALIGN_CHK_EN
    logic        id_exc_o;

    modport master (
        input  pc_i, ce_i, mem_ack_i, mem_rdata_i, id_ready_i, flush_i,
        output pc_take_o, mem_req_o, mem_addr_o, id_valid_o, id_pc_o, id_inst_o, id_exc_o
    );
    modport slave (
        output pc_i, ce_i, mem_ack_i, mem_rdata_i, id_ready_i, flush_i,
        input  pc_take_o, mem_req_o, mem_addr_o, id_valid_o, id_pc_o, id_inst_o, id_exc_o
    );
`else
    modport master (
        input  pc_i, ce_i, mem_ack_i, mem_rdata_i, id_ready_i, flush_i,
        output pc_take_o, mem_req_o, mem_addr_o, id_valid_o, id_pc_o, id_inst_o
    );
    modport slave (
        output pc_i, ce_i, mem_ack_i, mem_rdata_i, id_ready_i, flush_i,
        input  pc_take_o, mem_req_o, mem_addr_o, id_valid_o, id_pc_o, id_inst_o
    );
`endif
endinterface

// File: rtl/inst_fetch_buf.sv
// rtl/inst_fetch_buf.sv - instruction fetch stage: memory read FSM plus PC/instruction FIFO
//
// Optional feature macro: INST_FETCH_ALIGN_CHK_EN
//   defined   : misaligned pc_i issues no read and queues {pc_i, 32'h0, exc=1}
//   undefined : pc_i[1:0] ignored, fetch address forced word-aligned
// Parameters:
//   DEPTH  - FIFO entries (power of two, >= 2)
//   RST_PC - value shown on id_pc_o and mem_addr_o while in reset
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - inst_fetch_buf_if.master (PC stage, instruction memory, decode)

module inst_fetch_buf #(
    parameter int          DEPTH  = 2,
    parameter logic [31:0] RST_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_buf_if.master  bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   addr_q;

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic          accept;
    logic          misalign;
    logic          inflight;
    logic          ack_push;
    logic          exc_push;
    logic          push;
    logic          pop;
    logic [31:0]   push_pc;
    logic [31:0]   push_inst;

`ifdef INST_FETCH_ALIGN_CHK_EN
    logic          exc_pend_q;
    logic [31:0]   exc_pc_q;
    logic          exc_mem [DEPTH];

    assign misalign = |bus.pc_i[1:0];
    assign exc_push = exc_pend_q & ~bus.flush_i;
`else
    logic          unused_pc_lsb;

    assign unused_pc_lsb = ^bus.pc_i[1:0];
    assign misalign      = 1'b0;
    assign exc_push      = 1'b0;
`endif

    // Work accepted but not yet in the FIFO: an outstanding read, or a
    // misalignment entry that lands one cycle after acceptance.
`ifdef INST_FETCH_ALIGN_CHK_EN
    assign inflight = (state_q != IDLE) | exc_pend_q;
`else
    assign inflight = (state_q != IDLE);
`endif

    assign accept   = bus.ce_i & bus.pc_take_o;
    assign ack_push = (state_q == REQ) & bus.mem_ack_i & ~bus.flush_i;
    assign push     = ack_push | exc_push;
    assign pop      = bus.id_valid_o & bus.id_ready_i & ~bus.flush_i;

`ifdef INST_FETCH_ALIGN_CHK_EN
    assign push_pc   = exc_push ? exc_pc_q : addr_q;
    assign push_inst = exc_push ? 32'h0 : bus.mem_rdata_i;
`else
    assign push_pc   = addr_q;
    assign push_inst = bus.mem_rdata_i;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept & ~misalign) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // A flush without ack cannot withdraw the request; finish it in DRAIN.
                if (bus.mem_ack_i) begin
                    state_d = IDLE;
                end else if (bus.flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.mem_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Credit is taken from state and occupancy only, so the PC stage never
    // sees a combinational path from its own ce_i.
    always_comb begin
        bus.mem_req_o = 1'b0;
        bus.pc_take_o = 1'b0;
        case (state_q)
            IDLE:    bus.pc_take_o = ((count_q + CW'(inflight)) < CW'(DEPTH)) & ~bus.flush_i & ~rst;
            REQ:     bus.mem_req_o = 1'b1;
            DRAIN:   bus.mem_req_o = 1'b1;
            default: bus.mem_req_o = 1'b0;
        endcase
    end

    // ---------------- Fetch address ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= RST_PC;
        end else if (accept & ~misalign) begin
            addr_q <= {bus.pc_i[31:2], 2'b00};
        end
    end

    assign bus.mem_addr_o = addr_q;

`ifdef INST_FETCH_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_pend_q <= 1'b0;
            exc_pc_q   <= RST_PC;
        end else if (bus.flush_i) begin
            exc_pend_q <= 1'b0;
        end else begin
            exc_pend_q <= accept & misalign;
            if (accept & misalign) begin
                exc_pc_q <= bus.pc_i;
            end
        end
    end
`endif

    // ---------------- FIFO ----------------
    // The credit rule guarantees push never meets a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= RST_PC;
                inst_mem[i] <= '0;
`ifdef INST_FETCH_ALIGN_CHK_EN
                exc_mem[i]  <= 1'b0;
`endif
            end
        end else if (bus.flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr_q]   <= push_pc;
                inst_mem[wr_ptr_q] <= push_inst;
`ifdef INST_FETCH_ALIGN_CHK_EN
                exc_mem[wr_ptr_q]  <= exc_push;
`endif
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push & ~pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop & ~push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign bus.id_valid_o = (count_q != '0);
    assign bus.id_pc_o    = pc_mem[rd_ptr_q];
    assign bus.id_inst_o  = inst_mem[rd_ptr_q];
`ifdef INST_FETCH_ALIGN_CHK_EN
    assign bus.id_exc_o   = bus.id_valid_o & exc_mem[rd_ptr_q];
`endif

endmodule

// File: tb/tb_inst_fetch_buf.sv
// tb/tb_inst_fetch_buf.sv - scoreboard bench for inst_fetch_buf with randomized PC/memory/decode traffic

module tb_inst_fetch_buf;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_buf_if bus ();

    inst_fetch_buf #(.DEPTH(DEPTH), .RST_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        int          acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b0;
    int          last_acc = -1;
    bit          accepted = 1'b0;
    logic [31:0] last_pop_pc = 32'h0;

    int          p_rdy = 100;
    int          p_ce = 100;
    int          p_flush = 0;
    int          max_wait = 0;
    int          fixed_wait = -1;
    bit          random_pc = 1'b0;
    logic [31:0] next_pc = 32'h0;

    bit          in_req = 1'b0;
    int          wait_left = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock of stimulus: memory responder, input drive, model update.
    task automatic step(input bit r, input int ce_m, input int fl_m);
        logic [31:0] pc;
        exp_t        e;
        @(negedge clk);
        cyc++;
        rst = r;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = $urandom;
        if (r) begin
            in_req = 1'b0;
        end else if (bus.mem_req_o) begin
            if (!in_req) begin
                in_req    = 1'b1;
                wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(max_wait, 0));
            end
            if (wait_left == 0) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = memf(bus.mem_addr_o);
                in_req          = 1'b0;
            end else begin
                wait_left--;
            end
        end
        bus.id_ready_i = ($urandom_range(99, 0) < p_rdy);
        bus.ce_i       = (ce_m == 2) ? ($urandom_range(99, 0) < p_ce) : (ce_m != 0);
        bus.flush_i    = (fl_m == 2) ? ($urandom_range(99, 0) < p_flush) : (fl_m != 0);
        pc             = random_pc ? 32'($urandom) : next_pc;
        bus.pc_i       = pc;
        #1;
        if (r || bus.flush_i) exp_q.delete();
        accepted = bus.ce_i && bus.pc_take_o;
        if (accepted) begin
`ifdef INST_FETCH_ALIGN_CHK_EN
            if (pc[1:0] != 2'b00) begin
                e.pc = pc; e.inst = 32'h0; e.exc = 1'b1;
            end else begin
                e.pc = pc; e.inst = memf(pc); e.exc = 1'b0;
            end
`else
            e.pc = {pc[31:2], 2'b00}; e.inst = memf({pc[31:2], 2'b00}); e.exc = 1'b0;
`endif
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            checks++;
            if (exp_q.size() > DEPTH) begin
                errors++;
                $display("FAIL credit outstanding=%0d required<=%0d", exp_q.size(), DEPTH);
            end
            if (lat_chk && last_acc >= 0) chk("accept_gap", 32'(cyc - last_acc), 32'd2);
            last_acc = cyc;
            if (!random_pc) next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic accept_one(input logic [31:0] pc);
        int n = 0;
        next_pc = pc;
        accepted = 1'b0;
        while (!accepted && n < 20) begin
            step(0, 1, 0);
            n++;
        end
        chk("accept_one", {31'h0, accepted}, 32'h1);
    endtask

    task automatic drain();
        int n = 0;
        p_rdy = 100;
        while (exp_q.size() != 0 && n < 80) begin
            step(0, 0, 0);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (6) step(0, 0, 0);
    endtask

    // Monitor: compares the FIFO head against the model whenever it is valid.
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !bus.flush_i && bus.id_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_entry actual_pc=%h required=none", bus.id_pc_o);
                end else begin
`ifdef INST_FETCH_ALIGN_CHK_EN
                    if (bus.id_pc_o !== exp_q[0].pc || bus.id_inst_o !== exp_q[0].inst
                        || bus.id_exc_o !== exp_q[0].exc) begin
                        errors++;
                        $display("FAIL head actual=%h/%h/%b required=%h/%h/%b", bus.id_pc_o,
                                 bus.id_inst_o, bus.id_exc_o, exp_q[0].pc, exp_q[0].inst, exp_q[0].exc);
                    end
`else
                    if (bus.id_pc_o !== exp_q[0].pc || bus.id_inst_o !== exp_q[0].inst) begin
                        errors++;
                        $display("FAIL head actual=%h/%h required=%h/%h", bus.id_pc_o,
                                 bus.id_inst_o, exp_q[0].pc, exp_q[0].inst);
                    end
`endif
                    if (bus.id_ready_i) begin
                        if (lat_chk) chk("latency", 32'(cyc - exp_q[0].acc_cyc), 32'd2);
                        last_pop_pc = exp_q[0].pc;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (!rst && bus.mem_req_o) begin
                chk("addr_align", {30'h0, bus.mem_addr_o[1:0]}, 32'h0);
                if (prev_req && !prev_ack) chk("addr_stable", bus.mem_addr_o, prev_addr);
            end
            prev_req  = rst ? 1'b0 : bus.mem_req_o;
            prev_ack  = bus.mem_ack_i;
            prev_addr = bus.mem_addr_o;
        end
    end

    initial begin
        int n;
        bus.pc_i = 32'h0; bus.ce_i = 1'b1; bus.mem_ack_i = 1'b0; bus.mem_rdata_i = 32'h0;
        bus.id_ready_i = 1'b1; bus.flush_i = 1'b0;

        // Reset with ce_i high
        step(1, 1, 0);
        step(1, 1, 0);
        chk("rst_pc_take", {31'h0, bus.pc_take_o}, 32'h0);
        chk("rst_mem_req", {31'h0, bus.mem_req_o}, 32'h0);
        chk("rst_id_valid", {31'h0, bus.id_valid_o}, 32'h0);
        chk("rst_id_pc", bus.id_pc_o, 32'h0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("rst_id_inst", bus.id_inst_o, 32'h0);

        // Streaming, zero-wait memory: pc 0,4,8,... one entry per 2 cycles
        lat_chk = 1'b1;
        next_pc = 32'h0;
        step(0, 1, 0);
        chk("first_accept", {31'h0, accepted}, 32'h1);
        step(0, 1, 0);
        chk("first_req", {31'h0, bus.mem_req_o}, 32'h1);
        chk("first_addr", bus.mem_addr_o, 32'h0);
        repeat (12) step(0, 1, 0);
        lat_chk = 1'b0;

        // Back-pressure: decode stalled, credits exhausted
        p_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0);
            if (i >= 6) begin
                chk("bp_pc_take", {31'h0, bus.pc_take_o}, 32'h0);
                chk("bp_mem_req", {31'h0, bus.mem_req_o}, 32'h0);
                chk("bp_outstanding", 32'(exp_q.size()), 32'(DEPTH));
            end
        end
        p_rdy = 100;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0);
            if (accepted) n++;
        end
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL bp_resume accepts=%0d required>0", n);
        end
        drain();

        // Wait states: ack 3 cycles late at 0x10
        fixed_wait = 3;
        accept_one(32'h10);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0);
            if (bus.mem_req_o && bus.mem_addr_o == 32'h10) n++;
        end
        chk("wait_req_cycles", 32'(n), 32'd4);
        drain();

        // Flush while the read is outstanding, ack 2 cycles later
        fixed_wait = 2;
        accept_one(32'h40);
        step(0, 0, 1);
        chk("flush_in_req", {31'h0, bus.mem_req_o}, 32'h1);
        step(0, 0, 0);
        chk("drain_req", {31'h0, bus.mem_req_o}, 32'h1);
        chk("drain_addr", bus.mem_addr_o, 32'h40);
        chk("drain_empty_fifo", {31'h0, bus.id_valid_o}, 32'h0);
        fixed_wait = -1;
        accept_one(32'h100);
        drain();
        chk("post_flush_pc", last_pop_pc, 32'h100);

`ifdef INST_FETCH_ALIGN_CHK_EN
        // Misaligned fetch produces an exception entry without a memory read
        accept_one(32'h6);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            chk("misalign_no_req", {31'h0, bus.mem_req_o}, 32'h0);
        end
        drain();
        chk("misalign_pc", last_pop_pc, 32'h6);
`endif

        // Randomized traffic with a mid-run reset
        p_ce = 70; p_rdy = 60; p_flush = 5; max_wait = 3; random_pc = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                step(1, 2, 0);
                step(1, 2, 0);
            end else begin
                step(0, 2, 2);
            end
        end
        random_pc = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
